// File: rtl/clkdiv_sequencer_pkg.sv
// Shared types and defaults for the clock-enable divider sequencer.
package clkdiv_sequencer_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIV   = 25000000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

endpackage

// File: rtl/clkdiv_core.sv
// Half-period counter: counts up to div, then toggles clkout and pulses tick.
// When run is low the counter is parked at zero and clkout is held low.
module clkdiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [WIDTH-1:0] div,
  output logic             term,
  output logic             tick,
  output logic             clkout
);

  logic [WIDTH-1:0] cnt;

  // Terminal count only has meaning while running; the sequencer relies on this gating.
  assign term = run && (cnt == div);

  // Counter, divided clock and tick enable, all updated together so tick marks each clkout edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt    <= '0;
      clkout <= 1'b0;
      tick   <= 1'b0;
    end else if (!run) begin
      cnt    <= '0;
      clkout <= 1'b0;
      tick   <= 1'b0;
    end else if (term) begin
      cnt    <= '0;
      clkout <= ~clkout;
      tick   <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      tick   <= 1'b0;
    end
  end

endmodule

// File: rtl/clkdiv_sequencer.sv
// Start/stop sequencer and config handshake around clkdiv_core.
// New divide values are committed only at a terminal count so no half-period
// is ever truncated; a stop always finishes on a falling clkout edge.
// Optional build macro CLKDIV_SEQ_BURST_EN adds burst_len/done for counted bursts.
module clkdiv_sequencer
  import clkdiv_sequencer_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clkin,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
`ifdef CLKDIV_SEQ_BURST_EN
  input  logic [15:0]      burst_len,
  output logic             done,
`endif
  output logic             tick,
  output logic             clkout,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] pending;
  logic             pending_vld;
  logic             run;
  logic             term;
  logic             fall;
`ifdef CLKDIV_SEQ_BURST_EN
  logic [15:0]      burst_rem;
`endif

  assign run       = (state != IDLE);
  assign cfg_ready = (state == IDLE) || !pending_vld;
  // A terminal count while clkout is high is the falling edge of the divided clock.
  assign fall      = term && clkout;

  clkdiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clkin),
    .clr    (clr),
    .run    (run),
    .div    (div),
    .term   (term),
    .tick   (tick),
    .clkout (clkout)
  );

  // Pending payload carries no control meaning until pending_vld is set.
  always_ff @(posedge clkin) begin
    if (cfg_valid && cfg_ready && (state != IDLE))
      pending <= cfg_div;
  end

  // Sequencer FSM, divide register and pending commit; busy is registered alongside the state.
  always_ff @(posedge clkin) begin
    if (clr) begin
      state       <= IDLE;
      busy        <= 1'b0;
      div         <= WIDTH'(DEFAULT_DIV);
      pending_vld <= 1'b0;
`ifdef CLKDIV_SEQ_BURST_EN
      burst_rem   <= '0;
      done        <= 1'b0;
`endif
    end else begin
`ifdef CLKDIV_SEQ_BURST_EN
      done <= 1'b0;
      if (run && fall && (burst_rem != 16'd0))
        burst_rem <= burst_rem - 16'd1;
`endif
      // Accept and commit are exclusive outside IDLE: accept needs !pending_vld, commit needs it set.
      if (cfg_valid && cfg_ready) begin
        if (state == IDLE)
          div <= cfg_div;
        else
          pending_vld <= 1'b1;
      end
      if (term && pending_vld) begin
        div         <= pending;
        pending_vld <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= RUN;
            busy  <= 1'b1;
`ifdef CLKDIV_SEQ_BURST_EN
            burst_rem <= burst_len;
`endif
          end
        end
        RUN: begin
`ifdef CLKDIV_SEQ_BURST_EN
          if (fall && (burst_rem == 16'd1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else
`endif
          if (stop)
            state <= STOPPING;
        end
        STOPPING: begin
          if (start && !stop) begin
            state <= RUN;
          end else if (fall) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_sequencer.sv
// Directed, table-driven bench for clkdiv_sequencer (default build).
module tb_clkdiv_sequencer;

  localparam int W = 32;

  logic         clkin = 1'b0;
  logic         clr;
  logic         start;
  logic         stop;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         tick;
  logic         clkout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         start;
    logic         stop;
    logic         cv;
    logic [W-1:0] cd;
    logic         e_tick;
    logic         e_clk;
    logic         e_busy;
    logic         e_ready;
  } vec_t;

  vec_t vecs[$];

  clkdiv_sequencer #(
    .WIDTH       (W),
    .DEFAULT_DIV (5)
  ) dut (
    .clkin     (clkin),
    .clr       (clr),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .tick      (tick),
    .clkout    (clkout),
    .busy      (busy)
  );

  always #5 clkin = ~clkin;

  task automatic cyc();
    @(posedge clkin);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic cv, input logic [W-1:0] cd,
                     input logic et, input logic ec, input logic eb, input logic er);
    vec_t v;
    v.start = st; v.stop = sp; v.cv = cv; v.cd = cd;
    v.e_tick = et; v.e_clk = ec; v.e_busy = eb; v.e_ready = er;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic sp, input logic cv, input logic [W-1:0] cd);
    start = st; stop = sp; cfg_valid = cv; cfg_div = cd;
  endtask

  initial begin
    int gap;
    drive(0, 0, 0, 0);
    clr = 1'b1;
    cyc();
    cyc();
    chk("reset_tick", 0, tick, 0);
    chk("reset_clkout", 0, clkout, 0);
    chk("reset_busy", 0, busy, 0);
    chk("reset_ready", 0, cfg_ready, 1);
    clr = 1'b0;

    // div=3 in IDLE, then start: tick every 4, clkout period 8
    add(0,0,1,3, 0,0,0,1);
    add(1,0,0,0, 0,0,1,1);
    repeat (3) add(0,0,0,0, 0,0,1,1);
    add(0,0,0,0, 1,1,1,1);
    repeat (3) add(0,0,0,0, 0,1,1,1);
    add(0,0,0,0, 1,0,1,1);
    // offer div=1 mid-interval; second offer while not ready must be ignored
    add(0,0,1,1, 0,0,1,0);
    add(0,0,1,7, 0,0,1,0);
    add(0,0,0,0, 0,0,1,0);
    add(0,0,0,0, 1,1,1,1);
    add(0,0,0,0, 0,1,1,1);
    add(0,0,0,0, 1,0,1,1);
    add(0,0,0,0, 0,0,1,1);
    add(0,0,0,0, 1,1,1,1);
    // back to div=3
    add(0,0,1,3, 0,1,1,0);
    add(0,0,0,0, 1,0,1,1);
    repeat (3) add(0,0,0,0, 0,0,1,1);
    add(0,0,0,0, 1,1,1,1);
    repeat (3) add(0,0,0,0, 0,1,1,1);
    add(0,0,0,0, 1,0,1,1);
    // stop while clkout low: rises, then falls into IDLE
    add(0,1,0,0, 0,0,1,1);
    repeat (2) add(0,0,0,0, 0,0,1,1);
    add(0,0,0,0, 1,1,1,1);
    repeat (3) add(0,0,0,0, 0,1,1,1);
    add(0,0,0,0, 1,0,0,1);
    repeat (2) add(0,0,0,0, 0,0,0,1);
    // start and stop together in IDLE: stop wins
    add(1,1,0,0, 0,0,0,1);
    add(0,0,0,0, 0,0,0,1);
    // start, stop, then start again during STOPPING: spacing unbroken
    add(1,0,0,0, 0,0,1,1);
    repeat (3) add(0,0,0,0, 0,0,1,1);
    add(0,0,0,0, 1,1,1,1);
    add(0,1,0,0, 0,1,1,1);
    add(1,0,0,0, 0,1,1,1);
    add(0,0,0,0, 0,1,1,1);
    add(0,0,0,0, 1,0,1,1);
    repeat (3) add(0,0,0,0, 0,0,1,1);
    add(0,0,0,0, 1,1,1,1);
    // div=0: tick every cycle, then stop finishes on a falling edge
    add(0,0,1,0, 0,1,1,0);
    repeat (2) add(0,0,0,0, 0,1,1,0);
    add(0,0,0,0, 1,0,1,1);
    add(0,0,0,0, 1,1,1,1);
    add(0,0,0,0, 1,0,1,1);
    add(0,0,0,0, 1,1,1,1);
    add(0,1,0,0, 1,0,1,1);
    add(0,0,0,0, 1,1,1,1);
    add(0,0,0,0, 1,0,0,1);
    add(0,0,0,0, 0,0,0,1);

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].cv, vecs[i].cd);
      cyc();
      chk("tick", i, tick, vecs[i].e_tick);
      chk("clkout", i, clkout, vecs[i].e_clk);
      chk("busy", i, busy, vecs[i].e_busy);
      chk("cfg_ready", i, cfg_ready, vecs[i].e_ready);
    end

    // clr mid-interval with a pending config
    drive(0, 0, 1, 3); cyc();
    drive(1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0);
    repeat (5) cyc();
    drive(0, 0, 1, 1); cyc();
    chk("pre_clr_clkout", 0, clkout, 1);
    chk("pre_clr_ready", 0, cfg_ready, 0);
    drive(1, 0, 0, 0);
    clr = 1'b1;
    cyc();
    chk("clr_clkout", 0, clkout, 0);
    chk("clr_tick", 0, tick, 0);
    chk("clr_busy", 0, busy, 0);
    chk("clr_ready", 0, cfg_ready, 1);
    clr = 1'b0;
    cyc();
    chk("restart_busy", 0, busy, 1);
    drive(0, 0, 0, 0);
    // default divide of 5 gives 6 cycles per half-period; the discarded pending 1 must not appear
    for (int k = 0; k < 2; k++) begin
      gap = 0;
      for (int i = 1; i <= 20; i++) begin
        cyc();
        if (tick) begin
          gap = i;
          break;
        end
      end
      chk("default_div_gap", k, gap, 6);
    end
    drive(0, 1, 0, 0); cyc();
    drive(0, 0, 0, 0);
    gap = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (!busy) begin
        gap = i;
        break;
      end
    end
    chk("stop_reaches_idle", 0, (gap != 0), 1);
    chk("stop_parks_low", 0, clkout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
